// File: rtl/dmem_line_controller_if.sv
// Cache-to-memory line handshake: fill request, optional dirty-line writeback,
// fill data return and completion pulses.
interface dmem_line_controller_if;
  logic         reqD_mem;
  logic [25:0]  reqAddrD_mem;
  logic         reqD_cache_write;
  logic [127:0] data_to_mem;
  logic [25:0]  reqAddrD_write_mem;
  logic [127:0] data_from_mem;
  logic         read_ready_from_mem;
  logic         written_data_ack;
  logic         busy;

  modport master (
    output reqD_mem, reqAddrD_mem, reqD_cache_write, data_to_mem, reqAddrD_write_mem,
    input  data_from_mem, read_ready_from_mem, written_data_ack, busy
  );

  modport slave (
    input  reqD_mem, reqAddrD_mem, reqD_cache_write, data_to_mem, reqAddrD_write_mem,
    output data_from_mem, read_ready_from_mem, written_data_ack, busy
  );
endinterface

// File: rtl/dmem_line_controller.sv
// Main-memory line server behind the data cache: fixed-latency writeback then fill.
// Define DMEM_STATS_EN to add saturating read/writeback/busy-cycle counters.
//
//   state   | meaning
//   IDLE    | waiting for an armed request
//   WB_WAIT | counting down to the writeback array write
//   RD_WAIT | counting down to the fill array read
//   RESP    | fill data presented, closing the transaction
module dmem_line_controller #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  dmem_line_controller_if.slave  mem_if
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]            stat_reads,
  output logic [31:0]            stat_writebacks,
  output logic [31:0]            stat_busy_cycles
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WB_WAIT, RD_WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic [IW-1:0]   faddr_q, faddr_d;
  logic [IW-1:0]   waddr_q, waddr_d;
  logic [127:0]    wdata_q, wdata_d;
  logic [127:0]    rdata_q, rdata_d;
  logic            rdy_q, rdy_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            mem_we;
  logic            accept;
  logic            cnt_zero;

  logic [127:0]    mem_array [DEPTH];

  // Upper address bits are deliberately ignored; lines alias modulo DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_if.reqAddrD_mem[25:IW], mem_if.reqAddrD_write_mem[25:IW]};

  assign accept   = (state_q == IDLE) && armed_q && mem_if.reqD_mem;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      faddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      faddr_q <= faddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = mem_if.reqD_cache_write ? WB_WAIT : RD_WAIT;
      WB_WAIT: if (cnt_zero) state_d = RD_WAIT;
      RD_WAIT: if (cnt_zero) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    faddr_d = faddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;
    ack_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_if.reqD_mem) armed_d = 1'b1;
        if (accept) begin
          armed_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_RELOAD;
          faddr_d = mem_if.reqAddrD_mem[IW-1:0];
          waddr_d = mem_if.reqAddrD_write_mem[IW-1:0];
          wdata_d = mem_if.data_to_mem;
        end
      end
      WB_WAIT: begin
        if (cnt_zero) begin
          mem_we = 1'b1;
          ack_d  = 1'b1;
          cnt_d  = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RD_WAIT: begin
        if (cnt_zero) begin
          rdata_d = mem_array[faddr_q];
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // Backing store has no reset so its contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_array[waddr_q] <= wdata_q;
  end

  assign mem_if.data_from_mem       = rdata_q;
  assign mem_if.read_ready_from_mem = rdy_q;
  assign mem_if.written_data_ack    = ack_q;
  assign mem_if.busy                = busy_q;

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_reads       <= '0;
      stat_writebacks  <= '0;
      stat_busy_cycles <= '0;
    end else begin
      if (rdy_q  && (stat_reads       != '1)) stat_reads       <= stat_reads + 32'd1;
      if (ack_q  && (stat_writebacks  != '1)) stat_writebacks  <= stat_writebacks + 32'd1;
      if (busy_q && (stat_busy_cycles != '1)) stat_busy_cycles <= stat_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_line_controller.sv
// Randomized bench for dmem_line_controller against a line-level memory model
// with per-transaction timing expectations.
module tb_dmem_line_controller;
  localparam int LAT   = 4;
  localparam int DEPTH = 1024;
  localparam int IW    = 10;
  localparam int POOL  = 16;

  logic clk;
  logic rst_n;
  dmem_line_controller_if mem_if ();

`ifdef DMEM_STATS_EN
  logic [31:0] stat_reads, stat_writebacks, stat_busy_cycles;
`endif

  dmem_line_controller #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .mem_if (mem_if)
`ifdef DMEM_STATS_EN
    ,
    .stat_reads       (stat_reads),
    .stat_writebacks  (stat_writebacks),
    .stat_busy_cycles (stat_busy_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] model [int];
  int n_chk = 0;
  int n_err = 0;
  int exp_reads = 0;
  int exp_wbs = 0;
  int exp_busy = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [25:0] alias_addr(input int idx);
    logic [25:0] a;
    a = 26'($urandom);
    a[IW-1:0] = IW'(idx);
    return a;
  endfunction

  // Called just after a negedge; request is accepted on the following posedge.
  task automatic txn(input bit wr, input logic [25:0] waddr, input logic [127:0] wdata,
                     input logic [25:0] faddr, input int hold);
    int ack_at, ack_n, rdy_at, rdy_n, busy_n, extra_rdy;
    logic [127:0] exp_data, got;
    mem_if.reqD_mem           = 1'b1;
    mem_if.reqD_cache_write   = wr;
    mem_if.reqAddrD_write_mem = waddr;
    mem_if.data_to_mem        = wdata;
    mem_if.reqAddrD_mem       = faddr;
    if (wr) model[int'(waddr[IW-1:0])] = wdata;
    exp_data = model[int'(faddr[IW-1:0])];
    ack_at = -1; rdy_at = -1; ack_n = 0; rdy_n = 0; busy_n = 0; extra_rdy = 0;
    got = '0;
    for (int c = 0; c < 2*LAT + 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mem_if.reqD_cache_write   = 1'($urandom);
        mem_if.reqAddrD_write_mem = 26'($urandom);
        mem_if.data_to_mem        = rnd128();
        mem_if.reqAddrD_mem       = 26'($urandom);
      end
      if (mem_if.busy) busy_n++;
      if (mem_if.written_data_ack) begin
        ack_n++;
        if (ack_at < 0) ack_at = c;
      end
      if (mem_if.read_ready_from_mem) begin
        rdy_n++;
        rdy_at = c;
        got = mem_if.data_from_mem;
      end
    end
    chk("rdy_cycle", 128'(rdy_at), 128'(wr ? 2*LAT : LAT));
    chk("rdy_count", 128'(rdy_n), 128'd1);
    chk("ack_count", 128'(ack_n), 128'(wr ? 1 : 0));
    if (wr) chk("ack_cycle", 128'(ack_at), 128'(LAT));
    chk("busy_cycles", 128'(busy_n), 128'(wr ? 2*LAT+1 : LAT+1));
    chk("fill_data", got, exp_data);
    chk("data_hold", mem_if.data_from_mem, exp_data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (mem_if.read_ready_from_mem || mem_if.busy) extra_rdy++;
    end
    if (hold > 0) chk("no_reaccept", 128'(extra_rdy), 128'd0);
    exp_reads++;
    if (wr) exp_wbs++;
    exp_busy += wr ? 2*LAT+1 : LAT+1;
    mem_if.reqD_mem = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int idle_busy;
    logic [127:0] old12;
    rst_n = 1'b0;
    mem_if.reqD_mem = 1'b0;
    mem_if.reqD_cache_write = 1'b0;
    mem_if.reqAddrD_mem = '0;
    mem_if.reqAddrD_write_mem = '0;
    mem_if.data_to_mem = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", mem_if.data_from_mem, '0);
    chk("rst_rdy", 128'(mem_if.read_ready_from_mem), '0);
    chk("rst_ack", 128'(mem_if.written_data_ack), '0);
    chk("rst_busy", 128'(mem_if.busy), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Populate the line pool; each writeback fills the same line back.
    for (int i = 0; i < POOL; i++) begin
      logic [25:0] a;
      a = alias_addr(i);
      txn(1'b1, a, rnd128(), a, 0);
    end

    txn(1'b1, 26'd5, {16{8'hA5}}, 26'd0, 0);
    txn(1'b0, '0, '0, 26'd5, 0);
    chk("preload_5", mem_if.data_from_mem, {16{8'hA5}});
    txn(1'b1, 26'd3, 128'h1234, 26'd9, 0);
    txn(1'b0, '0, '0, 26'd3, 0);
    chk("wb_line3", mem_if.data_from_mem, 128'h1234);
    txn(1'b1, 26'd7, 128'hDEAD, 26'd7, 0);
    chk("same_line7", mem_if.data_from_mem, 128'hDEAD);
    txn(1'b0, '0, '0, 26'd2, 20);
    txn(1'b0, '0, '0, 26'd4, 0);

    mem_if.reqD_cache_write = 1'b1;
    idle_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_if.busy || mem_if.written_data_ack) idle_busy++;
    end
    chk("write_no_req", 128'(idle_busy), 128'd0);

    // Abort a writeback mid-flight; line 12 must keep its old contents.
    old12 = model[12];
    mem_if.reqD_mem = 1'b1;
    mem_if.reqD_cache_write = 1'b1;
    mem_if.reqAddrD_write_mem = 26'd12;
    mem_if.reqAddrD_mem = 26'd12;
    mem_if.data_to_mem = ~old12;
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 128'(mem_if.busy), 128'd1);
    rst_n = 1'b0;
    mem_if.reqD_mem = 1'b0;
    #1;
    chk("abort_busy", 128'(mem_if.busy), '0);
    chk("abort_rdy", 128'(mem_if.read_ready_from_mem), '0);
    chk("abort_ack", 128'(mem_if.written_data_ack), '0);
    chk("abort_data", mem_if.data_from_mem, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_reads = 0; exp_wbs = 0; exp_busy = 0;
    @(negedge clk);
    txn(1'b0, '0, '0, 26'd12, 0);
    chk("line12_kept", mem_if.data_from_mem, old12);

    for (int k = 0; k < 40; k++) begin
      bit wr;
      wr = 1'($urandom);
      txn(wr, alias_addr(int'($urandom_range(POOL-1, 0))), rnd128(),
          alias_addr(int'($urandom_range(POOL-1, 0))), (k % 10 == 0) ? 3 : 0);
    end

`ifdef DMEM_STATS_EN
    chk("stat_reads", 128'(stat_reads), 128'(exp_reads));
    chk("stat_writebacks", 128'(stat_writebacks), 128'(exp_wbs));
    chk("stat_busy_cycles", 128'(stat_busy_cycles), 128'(exp_busy));
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
